ram_refresh_sched: RTL

- Refresh scheduler for the FSB-side DRAM controller. It owns the refresh request/urgency handshake (RefReq, RefUrgent, RefAck) consumed by the RAM sequencer and the FSB cycle gate.
- Generates a refresh tick every REF_PERIOD CLK_FSB cycles and tracks owed refreshes in a pending counter.
- Escalates to urgent when refreshes are overdue, so the FSB stalls new cycles until the RAM sequencer catches up.

---
 rtl/ram_pkg.sv | 25 ++
 rtl/ref_tick_gen.sv | 36 +++
 rtl/ram_refresh_sched.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg
//   Shared definitions for the FSB-side DRAM controller refresh logic.
//   - refState_t : encoding of the refresh scheduler state machine
//   - *_DEF      : default timing constants (CLK_FSB = 25 MHz)
//   - cntWidth() : bit width needed to hold a count of 0..maxVal
package ram_pkg;

  typedef enum logic [1:0] {
    REF_IDLE   = 2'd0,
    REF_PEND   = 2'd1,
    REF_URGENT = 2'd2
  } refState_t;

  // 384 cycles at 25 MHz is one refresh every 15.36 us
  localparam int REF_PERIOD_DEF   = 384;
  localparam int URGENT_LEVEL_DEF = 2;
  localparam int URGENT_AGE_DEF   = 96;
  localparam int MAX_PENDING_DEF  = 4;

  // Never returns less than one bit, so degenerate parameters still elaborate
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/ref_tick_gen.sv
// ref_tick_gen
//   Enable-gated modulo-REF_PERIOD counter producing the refresh tick.
//   Ports:
//     CLK_FSB : FSB clock, rising edge
//     nRES    : asynchronous active-low reset
//     RefEn   : count enable; while low the counter freezes and no tick fires
//     tick    : high for the whole cycle in which the counter sits at REF_PERIOD-1
module ref_tick_gen
  import ram_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF
) (
  input  logic CLK_FSB,
  input  logic nRES,
  input  logic RefEn,
  output logic tick
);

  localparam int CNT_W = cntWidth(REF_PERIOD - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REF_PERIOD - 1);

  logic [CNT_W-1:0] tickCnt;

  // Free-running period counter. Holding (rather than clearing) while disabled
  // means a pause during DRAM init does not restart the refresh interval.
  always_ff @(posedge CLK_FSB or negedge nRES) begin
    if (!nRES) begin
      tickCnt <= '0;
    end else if (RefEn) begin
      tickCnt <= (tickCnt == LAST) ? '0 : tickCnt + 1'b1;
    end
  end

  assign tick = RefEn && (tickCnt == LAST);

endmodule

// File: rtl/ram_refresh_sched.sv
// ram_refresh_sched
//   Refresh scheduler for the FSB-side DRAM controller. Counts owed refreshes,
//   ages the oldest one and raises RefReq / RefUrgent for the RAM sequencer
//   and the FSB cycle gate.
//   Ports:
//     CLK_FSB     : FSB clock, rising edge
//     nRES        : asynchronous active-low reset
//     RefEn       : tick generation enable (low during DRAM init)
//     RefAck      : one-cycle pulse, one refresh performed
//     RefReq      : at least one refresh owed
//     RefUrgent   : refresh overdue, FSB must hold off new cycles
//     RefOverflow : sticky, a tick arrived while pending was saturated
//     PendingCnt  : current owed-refresh count
//   Optional (macro REF_STATS_EN):
//     StatClr     : synchronous clear of UrgentCnt, wins over an increment
//     UrgentCnt   : saturating count of entries into URGENT
module ram_refresh_sched
  import ram_pkg::*;
#(
  parameter int REF_PERIOD   = REF_PERIOD_DEF,
  parameter int URGENT_LEVEL = URGENT_LEVEL_DEF,
  parameter int URGENT_AGE   = URGENT_AGE_DEF,
  parameter int MAX_PENDING  = MAX_PENDING_DEF
) (
  input  logic        CLK_FSB,
  input  logic        nRES,
  input  logic        RefEn,
  input  logic        RefAck,
`ifdef REF_STATS_EN
  input  logic        StatClr,
  output logic [15:0] UrgentCnt,
`endif
  output logic        RefReq,
  output logic        RefUrgent,
  output logic        RefOverflow,
  output logic [2:0]  PendingCnt
);

  localparam int AGE_W = cntWidth(URGENT_AGE);
  localparam logic [AGE_W-1:0] AGE_MAX   = AGE_W'(URGENT_AGE);
  localparam logic [2:0]       PEND_MAX  = 3'(MAX_PENDING);
  localparam logic [2:0]       PEND_URG  = 3'(URGENT_LEVEL);

  logic             tick;
  logic [2:0]       pending, pendingNext;
  logic [AGE_W-1:0] age, ageNext;
  logic             overflowSet;
  logic             ackTaken;
  logic             overflow;
  refState_t        state, stateNext;

  ref_tick_gen #(
    .REF_PERIOD(REF_PERIOD)
  ) uTickGen (
    .CLK_FSB(CLK_FSB),
    .nRES   (nRES),
    .RefEn  (RefEn),
    .tick   (tick)
  );

  // Pending and age next-state. A tick and an ack in the same cycle cancel,
  // so a saturated counter does not flag overflow in that case. Any accepted
  // ack services the oldest request, which is why it also restarts the age.
  always_comb begin
    pendingNext = pending;
    overflowSet = 1'b0;
    ackTaken    = RefAck && (pending != 3'd0);
    if (tick && !RefAck) begin
      if (pending == PEND_MAX) overflowSet = 1'b1;
      else                     pendingNext = pending + 3'd1;
    end else if (RefAck && !tick && (pending != 3'd0)) begin
      pendingNext = pending - 3'd1;
    end

    if ((pending == 3'd0) || ackTaken) ageNext = '0;
    else if (age < AGE_MAX)            ageNext = age + 1'b1;
    else                               ageNext = age;
  end

  // Counter registers; overflow is sticky until reset
  always_ff @(posedge CLK_FSB or negedge nRES) begin
    if (!nRES) begin
      pending  <= '0;
      age      <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pendingNext;
      age      <= ageNext;
      if (overflowSet) overflow <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge CLK_FSB or negedge nRES) begin
    if (!nRES) state <= REF_IDLE;
    else       state <= stateNext;
  end

  // Next state is decoded from the next pending/age values so that the
  // registered outputs move on the same edge as the counters.
  always_comb begin
    stateNext = REF_PEND;
    if (pendingNext == 3'd0)
      stateNext = REF_IDLE;
    else if ((pendingNext >= PEND_URG) || (ageNext >= AGE_MAX))
      stateNext = REF_URGENT;
  end

  // Moore outputs straight from the state register
  always_comb begin
    RefReq    = 1'b0;
    RefUrgent = 1'b0;
    case (state)
      REF_PEND: RefReq = 1'b1;
      REF_URGENT: begin
        RefReq    = 1'b1;
        RefUrgent = 1'b1;
      end
      default: ;
    endcase
  end

  assign PendingCnt  = pending;
  assign RefOverflow = overflow;

`ifdef REF_STATS_EN
  // Counts fresh entries into URGENT; staying urgent does not count again
  always_ff @(posedge CLK_FSB or negedge nRES) begin
    if (!nRES)
      UrgentCnt <= '0;
    else if (StatClr)
      UrgentCnt <= '0;
    else if ((stateNext == REF_URGENT) && (state != REF_URGENT) && (UrgentCnt != 16'hFFFF))
      UrgentCnt <= UrgentCnt + 16'd1;
  end
`endif

endmodule
